rs_syndrome_calc: RTL and testbench

- Decoder front end for the RS(18,16) code; sits directly upstream of the GF_Adder/GF_Multiplier/GF_Divider error-evaluation logic.
- Accepts one received codeword symbol per cycle, highest degree first, over a valid/ready stream.
- Evaluates the two syndromes S1 = r(alpha^1) and S2 = r(alpha^2) by Horner accumulation.
- Presents both syndromes, plus an error flag, on a registered valid/ready output.

---
 rtl/rs_syndrome_calc_pkg.sv | 31 +++
 rtl/rs_syndrome_calc_if.sv | 43 ++++
 rtl/rs_syndrome_calc_gf_const_mul.sv | 22 ++
 rtl/rs_syndrome_calc.sv | 111 +++++++++++
 tb/tb_rs_syndrome_calc.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_syndrome_calc_pkg.sv
// Shared definitions for the RS(18,16) syndrome front end: symbol width,
// field polynomial, codeword length, the alpha^1/alpha^2 constants and
// the single-step multiply-by-alpha helper.
// The symbol width comes from the SYMBOL_WIDTH macro (default 8).
`ifndef SYMBOL_WIDTH
`define SYMBOL_WIDTH 8
`endif

package rs_syndrome_calc_pkg;

   localparam int SYM_W     = `SYMBOL_WIDTH;
   localparam int N_SYMBOLS = 18;
   localparam int CNT_W     = $clog2(N_SYMBOLS);

   // Field generator polynomial x^8 + x^4 + x^3 + x^2 + 1.
   localparam logic [SYM_W:0] PRIM_POLY = 9'h11D;

   // alpha is the root of PRIM_POLY, i.e. the polynomial x.
   localparam logic [SYM_W-1:0] ALPHA1 = SYM_W'(2);
   localparam logic [SYM_W-1:0] ALPHA2 = SYM_W'(4);

   // Multiply by alpha once: shift up one degree, fold the overflow back
   // in through the primitive polynomial.
   function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] a);
      logic [SYM_W:0] s;
      s = {a, 1'b0};
      if (s[SYM_W]) s = s ^ PRIM_POLY;
      return s[SYM_W-1:0];
   endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Stream bundle for the syndrome calculator: symbol input stream and
// syndrome result stream. The slave modport is the calculator itself.
// With RS_SYND_FRAME_CHECK_EN the bundle also carries in_last/frame_err.
//
// Handshake rule for both streams: a transfer happens on a rising clock
// edge where valid && ready; the source holds valid and data stable until
// that edge, and ready may depend combinationally on the sink's state.
import rs_syndrome_calc_pkg::*;

interface rs_syndrome_calc_if;

   logic             in_valid;
   logic             in_ready;
   logic [SYM_W-1:0] in_symbol;
   logic             synd_valid;
   logic             synd_ready;
   logic [SYM_W-1:0] syndrome1;
   logic [SYM_W-1:0] syndrome2;
   logic             err_detect;
`ifdef RS_SYND_FRAME_CHECK_EN
   logic             in_last;
   logic             frame_err;

   modport master (
      output in_valid, in_symbol, in_last, synd_ready,
      input  in_ready, synd_valid, syndrome1, syndrome2, err_detect, frame_err
   );
   modport slave (
      input  in_valid, in_symbol, in_last, synd_ready,
      output in_ready, synd_valid, syndrome1, syndrome2, err_detect, frame_err
   );
`else
   modport master (
      output in_valid, in_symbol, synd_ready,
      input  in_ready, synd_valid, syndrome1, syndrome2, err_detect
   );
   modport slave (
      input  in_valid, in_symbol, synd_ready,
      output in_ready, synd_valid, syndrome1, syndrome2, err_detect
   );
`endif

endinterface

// File: rtl/rs_syndrome_calc_gf_const_mul.sv
// Combinational multiply by the constant alpha^J, built as J repeated
// shift-and-reduce steps (J is small, so the chain stays shallow).
import rs_syndrome_calc_pkg::*;

module rs_syndrome_calc_gf_const_mul #(
   parameter int J = 1
) (
   input  logic [SYM_W-1:0] i_a,
   output logic [SYM_W-1:0] o_p
);

   logic [SYM_W-1:0] w_p;

   // Apply the multiply-by-alpha step J times.
   always_comb begin
      w_p = i_a;
      for (int k = 0; k < J; k++) w_p = gf_xtime(w_p);
   end

   assign o_p = w_p;

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(18,16) syndrome calculator. Takes one received symbol per accepted
// transfer, highest degree first, and Horner-accumulates S1 = r(alpha)
// and S2 = r(alpha^2). The final values land in a registered result
// stream together with err_detect.
// Optional: RS_SYND_FRAME_CHECK_EN adds in_last framing check / frame_err.
import rs_syndrome_calc_pkg::*;

module rs_syndrome_calc (
   input  logic              clk,
   input  logic              rst_n,
   rs_syndrome_calc_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SYMBOLS - 1);

   logic [CNT_W-1:0] r_sym_cnt;
   logic [SYM_W-1:0] r_acc1;
   logic [SYM_W-1:0] r_acc2;
   logic [SYM_W-1:0] r_synd1;
   logic [SYM_W-1:0] r_synd2;
   logic             r_synd_valid;
   logic             r_err;

   logic             w_last_pos;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_frame_bad;
   logic             w_load;
   logic [SYM_W-1:0] w_mul1;
   logic [SYM_W-1:0] w_mul2;
   logic [SYM_W-1:0] w_next1;
   logic [SYM_W-1:0] w_next2;

   rs_syndrome_calc_gf_const_mul #(.J(1)) u_mul1 (.i_a(r_acc1), .o_p(w_mul1));
   rs_syndrome_calc_gf_const_mul #(.J(2)) u_mul2 (.i_a(r_acc2), .o_p(w_mul2));

   assign w_last_pos = (r_sym_cnt == LAST_CNT);
   // Only the final symbol can be blocked: it would overwrite a result
   // that downstream has not taken yet. Earlier symbols never touch it.
   assign w_in_ready = !(w_last_pos && r_synd_valid && !bus.synd_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   // The first symbol of a codeword restarts the accumulators.
   assign w_next1 = (r_sym_cnt == '0 ? '0 : w_mul1) ^ bus.in_symbol;
   assign w_next2 = (r_sym_cnt == '0 ? '0 : w_mul2) ^ bus.in_symbol;

`ifdef RS_SYND_FRAME_CHECK_EN
   assign w_frame_bad = w_accept && (bus.in_last != w_last_pos);
`else
   assign w_frame_bad = 1'b0;
`endif
   assign w_load = w_accept && w_last_pos && !w_frame_bad;

   // Symbol position counter; wraps after the last symbol or on a
   // framing error so the next accepted symbol starts a fresh codeword.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_sym_cnt <= '0;
      else if (w_accept) begin
         if (w_last_pos || w_frame_bad) r_sym_cnt <= '0;
         else                           r_sym_cnt <= r_sym_cnt + 1'b1;
      end
   end

   // Horner accumulators for both syndromes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc1 <= '0;
         r_acc2 <= '0;
      end else if (w_accept) begin
         r_acc1 <= w_next1;
         r_acc2 <= w_next2;
      end
   end

   // Result register: a new load takes priority over a same-cycle consume,
   // so back-to-back results never lose the valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_synd1      <= '0;
         r_synd2      <= '0;
         r_err        <= 1'b0;
         r_synd_valid <= 1'b0;
      end else if (w_load) begin
         r_synd1      <= w_next1;
         r_synd2      <= w_next2;
         r_err        <= |(w_next1 | w_next2);
         r_synd_valid <= 1'b1;
      end else if (r_synd_valid && bus.synd_ready) begin
         r_synd_valid <= 1'b0;
      end
   end

`ifdef RS_SYND_FRAME_CHECK_EN
   logic r_frame_err;

   // One-cycle pulse for every symbol whose in_last disagrees with its position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_frame_err <= 1'b0;
      else        r_frame_err <= w_frame_bad;
   end

   assign bus.frame_err = r_frame_err;
`endif

   assign bus.in_ready   = w_in_ready;
   assign bus.synd_valid = r_synd_valid;
   assign bus.syndrome1  = r_synd1;
   assign bus.syndrome2  = r_synd2;
   assign bus.err_detect = r_err;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc. A reference model evaluates
// r(alpha^J) directly as a sum of symbol * (alpha^J)^degree; results are
// matched through an expected queue as the DUT hands them over.
import rs_syndrome_calc_pkg::*;

module tb_rs_syndrome_calc;

   typedef logic [7:0] word_t [N_SYMBOLS];

   logic clk;
   logic rst_n;
   rs_syndrome_calc_if bus();

   rs_syndrome_calc dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [16:0] exp_q[$];   // {err_detect, syndrome1, syndrome2}

   int   ready_mode  = 0;   // 0: ready_force, 1: random, 2: always high
   logic ready_force = 1'b0;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1D) : (a << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_pow(input logic [7:0] a, input int e);
      logic [7:0] r = 8'h01;
      for (int k = 0; k < e; k++) r = gf_mul(r, a);
      return r;
   endfunction

   function automatic logic [16:0] model(input word_t w);
      logic [7:0] s1 = 8'h00;
      logic [7:0] s2 = 8'h00;
      for (int i = 0; i < N_SYMBOLS; i++) begin
         s1 ^= gf_mul(w[i], gf_pow(8'h02, N_SYMBOLS - 1 - i));
         s2 ^= gf_mul(w[i], gf_pow(8'h04, N_SYMBOLS - 1 - i));
      end
      return {|(s1 | s2), s1, s2};
   endfunction

   // ---------------- result consumer ----------------
   initial begin
      bus.synd_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.synd_ready = ready_force;
            1:       bus.synd_ready = 1'($urandom_range(0, 1));
            default: bus.synd_ready = 1'b1;
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.synd_valid && bus.synd_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", 32'(bus.synd_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("syndrome1", 32'(bus.syndrome1), 32'(e[15:8]));
               check("syndrome2", 32'(bus.syndrome2), 32'(e[7:0]));
               check("err_detect", 32'(bus.err_detect), 32'(e[16]));
            end
         end
      end
   end

   // ---------------- drivers ----------------
   // Present one symbol and wait for it to be accepted. Called and returns
   // just after a rising edge.
   task automatic send_sym(input logic [7:0] sym, input logic last);
      logic acc;
      bus.in_valid  = 1'b1;
      bus.in_symbol = sym;
`ifdef RS_SYND_FRAME_CHECK_EN
      bus.in_last   = last;
`else
      if (last) acc = 1'b0;
`endif
      acc = 1'b0;
      for (int t = 0; t < 500 && !acc; t++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input word_t w, input int n_sym, input int last_at, input bit gaps);
      for (int i = 0; i < n_sym; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send_sym(w[i], i == last_at);
      end
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 1000 && exp_q.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      word_t w;
      word_t wb;
      bus.in_valid  = 1'b0;
      bus.in_symbol = 8'h00;
`ifdef RS_SYND_FRAME_CHECK_EN
      bus.in_last   = 1'b0;
`endif
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_synd_valid", 32'(bus.synd_valid), 32'd0);
      check("rst_syndrome1", 32'(bus.syndrome1), 32'd0);
      check("rst_syndrome2", 32'(bus.syndrome2), 32'd0);
      check("rst_err_detect", 32'(bus.err_detect), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef RS_SYND_FRAME_CHECK_EN
      check("rst_frame_err", 32'(bus.frame_err), 32'd0);
`endif
      rst_n = 1'b1;
      ready_mode = 2;
      @(posedge clk);
      #1;

      // All-zero codeword, with one-cycle result latency.
      foreach (w[i]) w[i] = 8'h00;
      send_word(w, N_SYMBOLS, N_SYMBOLS - 1, 1'b0);
      check("zero_latency_valid", 32'(bus.synd_valid), 32'd1);
      exp_q.push_back({1'b0, 8'h00, 8'h00});
      wait_drain();

      // 01 at degree 0.
      w[N_SYMBOLS-1] = 8'h01;
      send_word(w, N_SYMBOLS, N_SYMBOLS - 1, 1'b1);
      exp_q.push_back({1'b1, 8'h01, 8'h01});
      wait_drain();

      // 01 at degree 17: alpha^17 and alpha^34.
      foreach (w[i]) w[i] = 8'h00;
      w[0] = 8'h01;
      send_word(w, N_SYMBOLS, N_SYMBOLS - 1, 1'b1);
      exp_q.push_back({1'b1, 8'h98, 8'h4E});
      wait_drain();

      // Back-to-back codewords with the result stream stalled.
      ready_force = 1'b0;
      ready_mode  = 0;
      @(posedge clk);
      #1;
      foreach (w[i])  w[i]  = 8'($urandom_range(0, 255));
      foreach (wb[i]) wb[i] = 8'($urandom_range(0, 255));
      send_word(w, N_SYMBOLS, N_SYMBOLS - 1, 1'b0);
      exp_q.push_back(model(w));
      send_word(wb, N_SYMBOLS - 1, N_SYMBOLS - 1, 1'b0);
      bus.in_valid  = 1'b1;
      bus.in_symbol = wb[N_SYMBOLS-1];
`ifdef RS_SYND_FRAME_CHECK_EN
      bus.in_last   = 1'b1;
`endif
      repeat (2) begin
         @(negedge clk);
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_hold_valid", 32'(bus.synd_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      ready_force = 1'b1;
      @(negedge clk);
      check("release_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("b2b_valid_kept", 32'(bus.synd_valid), 32'd1);
      exp_q.push_back(model(wb));
      wait_drain();
      ready_mode = 2;

      // Reset in the middle of a codeword.
      foreach (w[i]) w[i] = 8'($urandom_range(0, 255));
      send_word(w, 9, N_SYMBOLS - 1, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(bus.synd_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_no_output", 32'(bus.synd_valid), 32'd0);
      foreach (w[i]) w[i] = 8'h00;
      send_word(w, N_SYMBOLS, N_SYMBOLS - 1, 1'b0);
      exp_q.push_back({1'b0, 8'h00, 8'h00});
      wait_drain();

`ifdef RS_SYND_FRAME_CHECK_EN
      // in_last asserted on symbol 10: frame dropped, pulse on frame_err.
      foreach (w[i]) w[i] = 8'($urandom_range(0, 255));
      send_word(w, 10, 9, 1'b0);
      check("frame_err_pulse", 32'(bus.frame_err), 32'd1);
      check("frame_no_valid", 32'(bus.synd_valid), 32'd0);
      @(posedge clk);
      #1;
      check("frame_err_clear", 32'(bus.frame_err), 32'd0);
      check("frame_still_no_valid", 32'(bus.synd_valid), 32'd0);
      send_word(w, N_SYMBOLS, N_SYMBOLS - 1, 1'b1);
      exp_q.push_back(model(w));
      wait_drain();
`endif

      // Randomized codewords, random gaps and random downstream ready.
      ready_mode = 1;
      for (int n = 0; n < 25; n++) begin
         foreach (w[i]) begin
            case ($urandom_range(0, 3))
               0:       w[i] = 8'h00;
               default: w[i] = 8'($urandom_range(0, 255));
            endcase
         end
         send_word(w, N_SYMBOLS, N_SYMBOLS - 1, 1'($urandom_range(0, 1)));
         check("rand_latency_valid", 32'(bus.synd_valid), 32'd1);
         exp_q.push_back(model(w));
      end
      ready_mode = 2;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
